// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM command-port arbiter: FSM states, port indices and the
// read-data pattern returned when a transaction times out.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  localparam logic        PORT_VID  = 1'b0;
  localparam logic        PORT_HOST = 1'b1;
  localparam logic [15:0] ERR_RDATA = 16'hDEAD;

endpackage

// File: rtl/ram_arb_prio_sel.sv
// Winner select for the two requesters: video has priority, except that the host port is
// forced once it has watched STARVE_MAX consecutive video grants.
module ram_arb_prio_sel
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic winner
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            forced;

  always_comb begin
    forced = (starve_q == CntW'(STARVE_MAX));
    winner = PORT_VID;
    if (req1 && (!req0 || forced)) begin
      winner = PORT_HOST;
    end
  end

  // A grant is made whenever grant_en is high and some port requests; with req1 high that holds.
  always_comb begin
    starve_d = starve_q;
    if (!req1) begin
      starve_d = '0;
    end else if (grant_en) begin
      if (winner == PORT_HOST) begin
        starve_d = '0;
      end else if (!forced) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM controller command port between the video read path and the serial host path,
// one transaction at a time. Define RAM_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_ack,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_err,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_ack,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_err,
  output logic              ram_wr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack_wr,
  input  logic              ram_ack_re,
  output logic              grant
);

  if (TIMEOUT_CYC < 2 || STARVE_MAX < 1) begin : g_param_check
    $error("ram_port_arbiter: TIMEOUT_CYC must be >= 2 and STARVE_MAX >= 1");
  end

  arb_state_e        state_q, state_d;
  logic              grant_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q, cap_data;
  logic              winner, match_ack, timeout;

  ram_arb_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio_sel (
    .clk     (clk),
    .reset   (reset),
    .req0    (rq0_req),
    .req1    (rq1_req),
    .grant_en(state_q == StIdle),
    .winner  (winner)
  );

  // Only the ack matching the strobe type completes a transaction.
  assign match_ack = we_q ? ram_ack_wr : ram_ack_re;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC);

  logic [ToW-1:0] to_cnt_q;

  assign timeout = (state_q == StWait) && !match_ack && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q != StWait) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rq0_req || rq1_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (match_ack || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cap_data = timeout ? DATA_W'(ERR_RDATA) : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= PORT_VID;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && state_d == StIssue) begin
        grant_q <= winner;
        we_q    <= (winner == PORT_HOST) ? rq1_we    : rq0_we;
        addr_q  <= (winner == PORT_HOST) ? rq1_addr  : rq0_addr;
        wdata_q <= (winner == PORT_HOST) ? rq1_wdata : rq0_wdata;
      end
      if (state_q == StWait && state_d == StResp) begin
        err_q <= timeout;
        if (!we_q) begin
          if (grant_q == PORT_HOST) begin
            rdata1_q <= cap_data;
          end else begin
            rdata0_q <= cap_data;
          end
        end
      end
    end
  end

  assign ram_wr    = (state_q == StIssue || state_q == StWait) && we_q;
  assign ram_re    = (state_q == StIssue || state_q == StWait) && !we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign grant     = grant_q;
  assign rq0_ack   = (state_q == StResp) && (grant_q == PORT_VID);
  assign rq1_ack   = (state_q == StResp) && (grant_q == PORT_HOST);
  assign rq0_err   = rq0_ack && err_q;
  assign rq1_err   = rq1_ack && err_q;
  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;

endmodule
